// File: rtl/ppu_scan_counter.sv
// Two-level PPU scan timing counter: {coarse, fine} dot position plus row,
// with programmable limits latched at reset, halt/load and a one-shot DONE state.
module ppu_scan_counter #(
  parameter int FINE_W   = 3,
  parameter int COARSE_W = 9,
  parameter int ROW_W    = 9
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_load,
  input  logic [COARSE_W-1:0]        i_load_val,
  input  logic                       i_halt,
  input  logic                       i_oneshot,
  input  logic [COARSE_W-1:0]        i_h_max,
  input  logic [ROW_W-1:0]           i_v_max,
  output logic [FINE_W+COARSE_W-1:0] o_counter,
  output logic [ROW_W-1:0]           o_row,
  output logic                       o_h_wrap,
  output logic                       o_v_wrap,
  output logic                       o_done,
  output logic                       o_running
);

  // state  | meaning
  // S_RUN  | counting (or frozen by halt)
  // S_DONE | one-shot frame finished, position held at 0 until load/reset
  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_DONE = 1'b1;

  localparam int CW = FINE_W + COARSE_W;

  logic [0:0]          r_state;
  logic [CW-1:0]       r_counter;
  logic [ROW_W-1:0]    r_row;
  logic                r_h_wrap;
  logic                r_v_wrap;
  logic [COARSE_W-1:0] r_h_max;
  logic [ROW_W-1:0]    r_v_max;
  logic                r_mode;

  logic [FINE_W-1:0]   w_fine;
  logic [COARSE_W-1:0] w_coarse;
  logic                w_h_term;
  logic                w_v_term;

  assign w_fine   = r_counter[FINE_W-1:0];
  assign w_coarse = r_counter[CW-1:FINE_W];
  // ">=" lets an overrange load run to the next fine terminal and wrap there
  assign w_h_term = (w_coarse >= r_h_max) && (&w_fine);
  assign w_v_term = w_h_term && (r_row >= r_v_max);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_RUN;
      r_counter <= '0;
      r_row     <= '0;
      r_h_wrap  <= 1'b0;
      r_v_wrap  <= 1'b0;
      r_h_max   <= i_h_max;
      r_v_max   <= i_v_max;
      r_mode    <= i_oneshot;
    end else if (i_load) begin
      r_state   <= S_RUN;
      r_counter <= {i_load_val, {FINE_W{1'b0}}};
      r_h_wrap  <= 1'b0;
      r_v_wrap  <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_counter <= '0;
      r_row     <= '0;
      r_h_wrap  <= 1'b0;
      r_v_wrap  <= 1'b0;
    end else if (i_halt) begin
      r_h_wrap  <= 1'b0;
      r_v_wrap  <= 1'b0;
    end else if (!w_h_term) begin
      r_counter <= r_counter + CW'(1);
      r_h_wrap  <= 1'b0;
      r_v_wrap  <= 1'b0;
    end else begin
      r_counter <= '0;
      r_h_wrap  <= 1'b1;
      if (w_v_term) begin
        r_row    <= '0;
        r_v_wrap <= 1'b1;
        if (r_mode) r_state <= S_DONE;
      end else begin
        r_row    <= r_row + ROW_W'(1);
        r_v_wrap <= 1'b0;
      end
    end
  end

  assign o_counter = r_counter;
  assign o_row     = r_row;
  assign o_h_wrap  = r_h_wrap;
  assign o_v_wrap  = r_v_wrap;
  assign o_done    = (r_state == S_DONE);
  assign o_running = (r_state == S_RUN) & ~i_halt;

endmodule

// File: tb/tb_ppu_scan_counter.sv
// Directed bench for ppu_scan_counter: wraps, one-shot DONE, halt/load priority,
// overrange load and mid-frame reset with limit relatch.
module tb_ppu_scan_counter;

  logic        clk;
  logic        reset;
  logic        load;
  logic [8:0]  load_val;
  logic        halt;
  logic        oneshot;
  logic [8:0]  h_max;
  logic [8:0]  v_max;
  logic [11:0] counter;
  logic [8:0]  row;
  logic        h_wrap;
  logic        v_wrap;
  logic        done;
  logic        running;

  int n_checks = 0;
  int n_pass   = 0;

  ppu_scan_counter #(.FINE_W(3), .COARSE_W(9), .ROW_W(9)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_load     (load),
    .i_load_val (load_val),
    .i_halt     (halt),
    .i_oneshot  (oneshot),
    .i_h_max    (h_max),
    .i_v_max    (v_max),
    .o_counter  (counter),
    .o_row      (row),
    .o_h_wrap   (h_wrap),
    .o_v_wrap   (v_wrap),
    .o_done     (done),
    .o_running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [8:0] hm, input logic [8:0] vm, input logic os);
    reset = 1'b1; h_max = hm; v_max = vm; oneshot = os;
    step(1);
    reset = 1'b0; h_max = 9'd0; v_max = 9'd0; oneshot = 1'b0;
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; load_val = '0; halt = 1'b0;
    oneshot = 1'b0; h_max = '0; v_max = '0;
    #2;

    // 1: basic line wrap, h_max=2 v_max=1
    do_reset(9'd2, 9'd1, 1'b0);
    check("rst_counter", counter, 0);
    check("rst_row", row, 0);
    check("rst_hwrap", h_wrap, 0);
    check("rst_vwrap", v_wrap, 0);
    check("rst_done", done, 0);
    check("rst_running", running, 1);
    step(23);
    check("t1_cnt23", counter, 23);
    check("t1_row0", row, 0);
    check("t1_hwrap_pre", h_wrap, 0);
    step(1);
    check("t1_wrap_cnt", counter, 0);
    check("t1_wrap_row", row, 1);
    check("t1_wrap_h", h_wrap, 1);
    check("t1_wrap_v", v_wrap, 0);
    step(1);
    check("t1_h_oneshot", h_wrap, 0);
    check("t1_cnt1", counter, 1);

    // 2: frame wrap at 48, repeats at 96
    step(23);
    check("t2_fr_cnt", counter, 0);
    check("t2_fr_row", row, 0);
    check("t2_fr_h", h_wrap, 1);
    check("t2_fr_v", v_wrap, 1);
    check("t2_fr_run", running, 1);
    step(1);
    check("t2_v_clear", v_wrap, 0);
    check("t2_counting", counter, 1);
    step(47);
    check("t2_fr2_v", v_wrap, 1);
    check("t2_fr2_h", h_wrap, 1);
    check("t2_fr2_row", row, 0);

    // 3: one-shot, h_max=0 v_max=2 -> 24-cycle frame then DONE
    do_reset(9'd0, 9'd2, 1'b1);
    step(8);
    check("t3_line_h", h_wrap, 1);
    check("t3_line_row", row, 1);
    step(16);
    check("t3_done", done, 1);
    check("t3_cnt", counter, 0);
    check("t3_row", row, 0);
    check("t3_h", h_wrap, 1);
    check("t3_v", v_wrap, 1);
    check("t3_running", running, 0);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("t3_hold_strobe", {30'd0, h_wrap, v_wrap}, 0);
      check("t3_hold_cnt", counter, 0);
    end
    check("t3_still_done", done, 1);
    load = 1'b1; load_val = 9'd0;
    step(1);
    load = 1'b0;
    check("t3_ld_running", running, 1);
    check("t3_ld_done", done, 0);
    check("t3_ld_cnt", counter, 0);
    check("t3_ld_h", h_wrap, 0);
    step(3);
    check("t3_resume", counter, 3);

    // 4: halt mid-line, then load overriding halt
    do_reset(9'd2, 9'd1, 1'b0);
    step(13);
    check("t4_cnt13", counter, 13);
    halt = 1'b1;
    #1;
    check("t4_running_low", running, 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("t4_hold_cnt", counter, 13);
      check("t4_hold_h", h_wrap, 0);
    end
    load = 1'b1; load_val = 9'd1;
    step(1);
    load = 1'b0; halt = 1'b0;
    check("t4_load_cnt", counter, 8);
    check("t4_load_row", row, 0);
    step(1);
    check("t4_after", counter, 9);

    // 5: overrange load, h_max=2, load_val=5
    do_reset(9'd2, 9'd1, 1'b0);
    load = 1'b1; load_val = 9'd5;
    step(1);
    load = 1'b0;
    check("t5_cnt40", counter, 40);
    step(7);
    check("t5_cnt47", counter, 47);
    check("t5_h_pre", h_wrap, 0);
    step(1);
    check("t5_wrap_cnt", counter, 0);
    check("t5_wrap_row", row, 1);
    check("t5_wrap_h", h_wrap, 1);

    // 6: reset mid-frame, relatch h_max=1
    do_reset(9'd2, 9'd1, 1'b0);
    step(41);
    check("t6_row1", row, 1);
    check("t6_cnt17", counter, 17);
    do_reset(9'd1, 9'd1, 1'b0);
    check("t6_rst_cnt", counter, 0);
    check("t6_rst_row", row, 0);
    check("t6_rst_hv", {30'd0, h_wrap, v_wrap}, 0);
    check("t6_rst_done", done, 0);
    step(15);
    check("t6_cnt15", counter, 15);
    check("t6_h_pre", h_wrap, 0);
    step(1);
    check("t6_h16", h_wrap, 1);
    check("t6_row16", row, 1);
    step(16);
    check("t6_h32", h_wrap, 1);
    check("t6_v32", v_wrap, 1);
    check("t6_row32", row, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ppu_scan_counter.md
Name: ppu_scan_counter

Overview:
- Parametrised two-level scan timing counter for the PPU.
- Horizontal counter: a fine sub-dot field (low FINE_W bits) plus a coarse dot field. Row counter advances on every horizontal wrap.
- Limits are programmable and latched at reset. Supports halt, load, and a one-shot frame mode with a DONE state.
- Feeds tile fetch and sprite evaluation logic with dot/row position and registered wrap strobes.

Parameters:
FINE_W, 3, width of fine sub-dot field (coarse advances every 2^FINE_W cycles)
COARSE_W, 9, width of coarse dot field and of h_max/load_val
ROW_W, 9, width of row counter and v_max

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous active-high reset; also latches h_max, v_max, oneshot
load  input  1  load coarse start position; restarts from DONE
load_val  input  COARSE_W  coarse value loaded; fine field loads 0
halt  input  1  freeze counter/row while high (RUN only)
oneshot  input  1  mode select, sampled only during RESET: 1 = stop after one frame
h_max  input  COARSE_W  last coarse dot of a line, sampled during RESET
v_max  input  ROW_W  last row of a frame, sampled during RESET
counter  output  FINE_W+COARSE_W  {coarse, fine} horizontal position
row  output  ROW_W  current row
h_wrap  output  1  one-cycle registered strobe: line wrapped
v_wrap  output  1  one-cycle registered strobe: frame wrapped
done  output  1  high in DONE state
running  output  1  high in RUN state with halt low

Behaviour:
- State machine: RUN, DONE.
- Priority per cycle: RESET > load > halt > count.
- RESET:
  - state=RUN; counter=0, row=0, h_wrap=0, v_wrap=0, done=0.
  - h_max_q<=h_max, v_max_q<=v_max, mode_q<=oneshot.
  - Reset mid-frame or in DONE behaves identically.
- load (any state):
  - counter<={load_val, FINE_W'b0}; row unchanged; state=RUN; h_wrap=v_wrap=0 next cycle.
  - Overrides halt.
- halt in RUN: counter, row, state hold; strobes 0 next cycle. halt in DONE: no effect.
- Line terminal (h_term): coarse >= h_max_q AND fine == all ones.
  - ">=" covers load_val > h_max_q: the counter runs on to the first terminal and wraps there, never past the coarse width.
- Frame terminal: h_term AND row >= v_max_q.
- Count step in RUN (no load, no halt):
  - Not h_term: counter+1, row holds.
  - h_term, not frame terminal: counter=0, row+1, h_wrap=1 next cycle.
  - Frame terminal, mode_q=0: counter=0, row=0, h_wrap=1 and v_wrap=1 next cycle, stay RUN.
  - Frame terminal, mode_q=1: counter=0, row=0, h_wrap=v_wrap=1 next cycle, state=DONE.
- DONE: counter=0, row=0 held; done=1; strobes 0 after the single wrap cycle. Exit via load (RUN) or RESET.
- Strobe timing: h_wrap/v_wrap are registered, high exactly one cycle, and coincide with the cycle counter first reads 0 after the wrap. Never high from load or reset.
- Line period: (h_max_q+1)·2^FINE_W cycles from counter=0. h_max_q=0 gives 2^FINE_W.
- Frame period: (v_max_q+1) × line period.
- All arithmetic is unsigned. No overflow is reachable, because the terminal compare wraps first.
- running = (state==RUN) & ~halt, combinational from state.

Test Plan:
1. Basic line wrap: RESET with h_max=2, v_max=1, oneshot=0 → counter 0..23 over 24 cycles; cycle 24: counter=0, row=1, h_wrap=1, v_wrap=0.
2. Frame wrap and free run: same config, 48 cycles → counter=0, row=0, h_wrap=v_wrap=1 for one cycle; counting continues; 48 cycles later the same pulse repeats.
3. One-shot: RESET with oneshot=1, h_max=0, v_max=2 → 24 cycles then done=1, counter=0, row=0; held 20 cycles with no strobes; load with load_val=0 → running=1, counting resumes.
4. Halt and load priority: halt for 5 cycles mid-line at counter=13 → counter holds 13, no strobes. Assert load (load_val=1) with halt still high → counter=8 next cycle.
5. Overrange load: h_max=2, load_val=5 → counter counts 40..47; at 47 wraps to 0, row+1, h_wrap=1.
6. Reset mid-frame and limit relatch: at row=1, counter=17, RESET with h_max=1 → all outputs 0; new line period = 16 cycles confirmed by h_wrap spacing.
